// File: rtl/lgn_pkg.sv
// Shared LGN definitions: default geometry of the output stage and the scorer FSM states.
package lgn_pkg;

    localparam int CLASSES_DEF = 10;
    localparam int N_DEF       = 15;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/lgn_popcount.sv
// Purely combinational N-bit population count; zero latency, no handshake.
module lgn_popcount #(
    parameter  int N       = 15,
    localparam int SCORE_W = $clog2(N + 1)
) (
    input  logic [N-1:0]       in,
    output logic [SCORE_W-1:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            out = out + SCORE_W'(in[i]);
        end
    end

endmodule

// File: rtl/lgn_class_scorer.sv
// Snapshots the LGN outputs on start, scores one class per cycle and tracks the argmax.
// Result ready CLASSES cycles after the accept edge; start is ignored while busy.
module lgn_class_scorer
    import lgn_pkg::*;
#(
    parameter  int CLASSES = CLASSES_DEF,
    parameter  int N       = N_DEF,
    localparam int SCORE_W = $clog2(N + 1),
    localparam int IDX_W   = $clog2(CLASSES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CLASSES*N-1:0] in_bits,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     class_out,
    output logic [SCORE_W-1:0]   best_score,
    input  logic [IDX_W-1:0]     sel,
    output logic [SCORE_W-1:0]   sel_score
);

    state_t                 state;
    logic [CLASSES*N-1:0]   snapshot;
    logic [IDX_W-1:0]       cnt;
    logic [SCORE_W-1:0]     score [CLASSES];
    logic [N-1:0]           cur_slice;
    logic [SCORE_W-1:0]     cur_pop;

    always_comb begin
        cur_slice = '0;
        for (int c = 0; c < CLASSES; c++) begin
            if (cnt == IDX_W'(c)) begin
                cur_slice = snapshot[c*N +: N];
            end
        end
    end

    lgn_popcount #(.N(N)) u_popcount (
        .in  (cur_slice),
        .out (cur_pop)
    );

    // Out-of-range selects fall through to zero rather than aliasing a real class.
    always_comb begin
        sel_score = '0;
        for (int c = 0; c < CLASSES; c++) begin
            if (sel == IDX_W'(c)) begin
                sel_score = score[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            class_out  <= '0;
            best_score <= '0;
            snapshot   <= '0;
            for (int c = 0; c < CLASSES; c++) begin
                score[c] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= COUNT;
                        snapshot   <= in_bits;
                        cnt        <= '0;
                        best_score <= '0;
                        class_out  <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                COUNT: begin
                    for (int c = 0; c < CLASSES; c++) begin
                        if (cnt == IDX_W'(c)) begin
                            score[c] <= cur_pop;
                        end
                    end
                    // Strict compare keeps the lowest index on ties.
                    if (cnt == '0 || cur_pop > best_score) begin
                        best_score <= cur_pop;
                        class_out  <= cnt;
                    end
                    if (cnt == IDX_W'(CLASSES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_class_scorer.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each completed pass.
`timescale 1ns/1ps
module tb_lgn_class_scorer;

    localparam int CLASSES = 10;
    localparam int N       = 15;
    localparam int SCORE_W = 4;
    localparam int IDX_W   = 4;
    localparam int W       = CLASSES * N;

    typedef struct packed {
        logic [IDX_W-1:0]                 cls;
        logic [SCORE_W-1:0]               best;
        logic [CLASSES-1:0][SCORE_W-1:0]  sc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [W-1:0]       in_bits = '0;
    logic               busy, done;
    logic [IDX_W-1:0]   class_out;
    logic [SCORE_W-1:0] best_score;
    logic [IDX_W-1:0]   sel = '0;
    logic [SCORE_W-1:0] sel_score;

    int   checks = 0;
    int   failures = 0;
    int   zero_req = 0;
    int   zero_ack = 0;
    exp_t sb [$];

    lgn_class_scorer #(.CLASSES(CLASSES), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_bits    (in_bits),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out),
        .best_score (best_score),
        .sel        (sel),
        .sel_score  (sel_score)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] bits);
        exp_t e;
        int   best;
        e = '0;
        best = -1;
        for (int c = 0; c < CLASSES; c++) begin
            int p;
            p = $countones(bits[c*N +: N]);
            e.sc[c] = SCORE_W'(p);
            if (p > best) begin
                best  = p;
                e.cls = IDX_W'(c);
            end
        end
        e.best = SCORE_W'(best);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bits(input int density);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) begin
            b[i] = ($urandom_range(99) < density);
        end
        return b;
    endfunction

    // Monitor: owns sel; checks every completed pass and any post-reset zero scans.
    initial begin : monitor
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("class_out", int'(class_out), int'(e.cls));
                    check("best_score", int'(best_score), int'(e.best));
                    for (int s = 0; s < 16; s++) begin
                        sel = IDX_W'(s);
                        #1;
                        check($sformatf("sel_score[%0d]", s), int'(sel_score),
                              (s < CLASSES) ? int'(e.sc[s]) : 0);
                    end
                end
            end
            if (zero_ack != zero_req) begin
                for (int s = 0; s < 16; s++) begin
                    sel = IDX_W'(s);
                    #1;
                    check($sformatf("zero_score[%0d]", s), int'(sel_score), 0);
                end
                zero_ack++;
            end
            done_q = done;
        end
    end

    task automatic run_pass(input logic [W-1:0] bits, input int poke_at, input int rst_at);
        int cyc;
        bit got;
        sb.push_back(model(bits));
        @(negedge clk);
        in_bits = bits;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", int'(busy), 1);
        check("accept_done", int'(done), 0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == poke_at) begin
                in_bits = ~bits;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_class", int'(class_out), 0);
                check("rst_best", int'(best_score), 0);
                void'(sb.pop_back());
                zero_req++;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check("done_latency", cyc, CLASSES);
        check("done_busy", int'(busy), 0);
    endtask

    initial begin : stimulus
        logic [W-1:0] b;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_class", int'(class_out), 0);
        check("reset_best", int'(best_score), 0);
        zero_req++;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_pass('0, 0, 0);

        b = '0;
        b[7*N +: N] = 15'h7FFF;
        b[2*N +: N] = 15'h00FF;
        run_pass(b, 0, 0);

        b = '0;
        for (int c = 0; c < CLASSES; c++) b[c*N +: N] = 15'h007F;
        b[3*N +: N] = 15'h0F0F;
        b[8*N +: N] = 15'h0F0F;
        run_pass(b, 0, 0);

        run_pass(rand_bits(50), 4, 0);
        run_pass(rand_bits(50), 0, 5);
        run_pass(rand_bits(70), 0, 0);

        for (int i = 0; i < 15; i++) begin
            run_pass(rand_bits($urandom_range(100)), 0, 0);
        end

        for (int i = 0; i < 40 && (sb.size() != 0 || zero_ack != zero_req); i++) begin
            @(negedge clk);
        end
        check("scoreboard_empty", sb.size(), 0);
        check("zero_scans_done", zero_ack, zero_req);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
